// File: rtl/nios_system_onchip_memory_dp_pkg.sv
// Shared constants and elaboration helpers for the
// dual-port on-chip memory.
package nios_system_onchip_memory_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic int be_width(input int dw);
    return dw / 8;
  endfunction

  function automatic bit params_ok(
    input int dw,
    input int aw,
    input int depth,
    input int lat
  );
    return (dw > 0) && (dw % 8 == 0) &&
           (aw > 0) && (aw < 32) &&
           (depth >= 2) &&
           (longint'(depth) <= (64'd1 << aw)) &&
           (lat >= LAT_MIN) && (lat <= LAT_MAX);
  endfunction

endpackage

// File: rtl/nios_system_onchip_memory_dp_if.sv
// One Avalon-MM slave port of the dual-port memory.
// Widths must match the memory's DATA_WIDTH/ADDR_WIDTH.
interface nios_system_onchip_memory_dp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);

  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, chipselect, read, write,
    output byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write,
    input  byteenable, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/nios_system_onchip_memory_dp_rdpipe.sv
// Read-return pipeline for one port: valid shift
// register plus optional second data register.
module nios_system_onchip_memory_rdpipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en_i,
  input  logic                  accept_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic [DATA_WIDTH-1:0] readdata_o,
  output logic                  readdatavalid_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   d1_q;

  // Valid tokens advance only on enabled edges.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_q <= '0;
    end else if (en_i) begin
      vld_q <= READ_LATENCY'({vld_q, accept_i});
    end
  end

  // First data stage captures the array word on accept.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      d1_q <= '0;
    end else if (en_i && accept_i) begin
      d1_q <= rdata_i;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] out_q;

    // Output stage only moves with a real token.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        out_q <= '0;
      end else if (en_i && vld_q[0]) begin
        out_q <= d1_q;
      end
    end

    assign readdata_o = out_q;
  end else begin : g_lat1
    assign readdata_o = d1_q;
  end

  assign readdatavalid_o = vld_q[READ_LATENCY-1] & en_i;

endmodule

// File: rtl/nios_system_onchip_memory_dp.sv
// True dual-port on-chip RAM, two Avalon-MM slaves,
// s1 wins per byte lane on same-address writes.
module nios_system_onchip_memory_dp
  import nios_system_onchip_memory_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 11,
  parameter int    DEPTH        = 2048,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic reset_req,
  nios_system_onchip_memory_dp_if.slave s1,
  nios_system_onchip_memory_dp_if.slave s2,
  output logic collision
);

  localparam int BW  = be_width(DATA_WIDTH);
  localparam int AIW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH, READ_LATENCY))
  begin : g_bad_params
    $error("nios_system_onchip_memory_dp: bad parameters");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic           en;
  logic           acc_en;
  logic           in1, in2;
  logic [AIW-1:0] idx1, idx2;
  logic           we1, we2;
  logic           re1, re2;
  logic [DATA_WIDTH-1:0] rd1, rd2;
  logic           collision_q;

  // Reset blocks new accesses but leaves the array intact.
  assign en     = clken & ~reset_req;
  assign acc_en = en & reset_n;

  assign in1  = int'(s1.address) < DEPTH;
  assign in2  = int'(s2.address) < DEPTH;
  assign idx1 = s1.address[AIW-1:0];
  assign idx2 = s2.address[AIW-1:0];

  assign we1 = s1.chipselect & s1.write & acc_en & in1;
  assign we2 = s2.chipselect & s2.write & acc_en & in2;
  assign re1 = s1.chipselect & s1.read & ~s1.write & acc_en;
  assign re2 = s2.chipselect & s2.read & ~s2.write & acc_en;

  // Out-of-range reads return zero but still complete.
  assign rd1 = in1 ? mem[idx1] : '0;
  assign rd2 = in2 ? mem[idx2] : '0;

  // s2 lanes first; an s1 write to the same lane
  // comes later and therefore overrides it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BW; i++) begin
      if (we2 && s2.byteenable[i]) begin
        mem[idx2][8*i +: 8] <= s2.writedata[8*i +: 8];
      end
      if (we1 && s1.byteenable[i]) begin
        mem[idx1][8*i +: 8] <= s1.writedata[8*i +: 8];
      end
    end
  end

  // Sticky flag for same-address writes on both ports.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      collision_q <= 1'b0;
    end else if (we1 && we2 && (idx1 == idx2)) begin
      collision_q <= 1'b1;
    end
  end

  assign collision = collision_q;

  nios_system_onchip_memory_rdpipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (en),
    .accept_i       (re1),
    .rdata_i        (rd1),
    .readdata_o     (s1.readdata),
    .readdatavalid_o(s1.readdatavalid)
  );

  nios_system_onchip_memory_rdpipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe2 (
    .clk            (clk),
    .reset_n        (reset_n),
    .en_i           (en),
    .accept_i       (re2),
    .rdata_i        (rd2),
    .readdata_o     (s2.readdata),
    .readdatavalid_o(s2.readdatavalid)
  );

endmodule

// File: tb/tb_nios_system_onchip_memory_dp.sv
// Directed bench: one latency-1 and one latency-2
// memory driven with identical stimulus.
module tb_nios_system_onchip_memory_dp;

  logic clk = 1'b0;
  logic reset_n;
  logic clken;
  logic reset_req;
  logic coll_a, coll_b;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  nios_system_onchip_memory_dp_if #(32, 5) ia1 ();
  nios_system_onchip_memory_dp_if #(32, 5) ia2 ();
  nios_system_onchip_memory_dp_if #(32, 5) ib1 ();
  nios_system_onchip_memory_dp_if #(32, 5) ib2 ();

  nios_system_onchip_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(1), .INIT_FILE("")
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .s1(ia1), .s2(ia2),
    .collision(coll_a)
  );

  nios_system_onchip_memory_dp #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(16),
    .READ_LATENCY(2), .INIT_FILE("")
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .reset_req(reset_req), .s1(ib1), .s2(ib2),
    .collision(coll_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h",
                tag, obs, exp);
  endtask

  task automatic p1(input logic cs, input logic rd,
                    input logic wr, input logic [4:0] a,
                    input logic [3:0] be,
                    input logic [31:0] wd);
    ia1.chipselect = cs; ib1.chipselect = cs;
    ia1.read = rd;       ib1.read = rd;
    ia1.write = wr;      ib1.write = wr;
    ia1.address = a;     ib1.address = a;
    ia1.byteenable = be; ib1.byteenable = be;
    ia1.writedata = wd;  ib1.writedata = wd;
  endtask

  task automatic p2(input logic cs, input logic rd,
                    input logic wr, input logic [4:0] a,
                    input logic [3:0] be,
                    input logic [31:0] wd);
    ia2.chipselect = cs; ib2.chipselect = cs;
    ia2.read = rd;       ib2.read = rd;
    ia2.write = wr;      ib2.write = wr;
    ia2.address = a;     ib2.address = a;
    ia2.byteenable = be; ib2.byteenable = be;
    ia2.writedata = wd;  ib2.writedata = wd;
  endtask

  task automatic idle;
    p1(0, 0, 0, 5'd0, 4'h0, 32'h0);
    p2(0, 0, 0, 5'd0, 4'h0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    clken = 1'b1;
    reset_req = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_a1_data", ia1.readdata, 32'h0);
    chk("rst_a1_vld", {31'b0, ia1.readdatavalid}, 32'h0);
    chk("rst_b2_data", ib2.readdata, 32'h0);
    chk("rst_b2_vld", {31'b0, ib2.readdatavalid}, 32'h0);
    chk("rst_coll_a", {31'b0, coll_a}, 32'h0);
    chk("rst_coll_b", {31'b0, coll_b}, 32'h0);
    reset_n = 1'b1;

    // write then read, latency 1 and 2
    @(negedge clk); p1(1, 0, 1, 5'd5, 4'hF, 32'h12345678);
    @(negedge clk); p1(1, 1, 0, 5'd5, 4'h0, 32'h0);
    @(negedge clk); idle(); #1;
    chk("t1_a_vld", {31'b0, ia1.readdatavalid}, 32'h1);
    chk("t1_a_data", ia1.readdata, 32'h12345678);
    chk("t1_b_vld_early", {31'b0, ib1.readdatavalid}, 32'h0);
    @(negedge clk); #1;
    chk("t1_a_vld_once", {31'b0, ia1.readdatavalid}, 32'h0);
    chk("t1_b_vld", {31'b0, ib1.readdatavalid}, 32'h1);
    chk("t1_b_data", ib1.readdata, 32'h12345678);
    @(negedge clk); #1;
    chk("t1_b_vld_once", {31'b0, ib1.readdatavalid}, 32'h0);

    // partial byte-enable write from s2
    @(negedge clk); p2(1, 0, 1, 5'd5, 4'b0101, 32'hAABBCCDD);
    @(negedge clk); idle(); p1(1, 1, 0, 5'd5, 4'h0, 32'h0);
    @(negedge clk); idle(); #1;
    chk("t2_a_data", ia1.readdata, 32'h12BB56DD);
    @(negedge clk); #1;
    chk("t2_b_data", ib1.readdata, 32'h12BB56DD);

    // write-write collision at addr 9
    @(negedge clk);
    p1(1, 0, 1, 5'd9, 4'b0011, 32'h11111111);
    p2(1, 0, 1, 5'd9, 4'b1111, 32'h22222222);
    @(negedge clk);
    p1(1, 1, 0, 5'd9, 4'h0, 32'h0);
    p2(1, 1, 0, 5'd9, 4'h0, 32'h0);
    #1;
    chk("t3_coll_a", {31'b0, coll_a}, 32'h1);
    chk("t3_coll_b", {31'b0, coll_b}, 32'h1);
    @(negedge clk); idle(); #1;
    chk("t3_a1_data", ia1.readdata, 32'h22221111);
    chk("t3_a2_data", ia2.readdata, 32'h22221111);
    chk("t3_a2_vld", {31'b0, ia2.readdatavalid}, 32'h1);
    repeat (100) @(negedge clk);
    #1;
    chk("t3_coll_sticky", {31'b0, coll_a}, 32'h1);

    // mixed-port read during write, out-of-range read
    @(negedge clk); p1(1, 0, 1, 5'd7, 4'hF, 32'hDEAD0000);
    @(negedge clk);
    p1(1, 1, 0, 5'd7, 4'h0, 32'h0);
    p2(1, 0, 1, 5'd7, 4'hF, 32'hBEEF0001);
    @(negedge clk);
    p1(1, 1, 0, 5'd16, 4'h0, 32'h0);
    p2(0, 0, 0, 5'd0, 4'h0, 32'h0);
    #1;
    chk("t6_old_vld", {31'b0, ia1.readdatavalid}, 32'h1);
    chk("t6_old_data", ia1.readdata, 32'hDEAD0000);
    @(negedge clk); p1(1, 1, 0, 5'd7, 4'h0, 32'h0); #1;
    chk("t6_oor_vld", {31'b0, ia1.readdatavalid}, 32'h1);
    chk("t6_oor_data", ia1.readdata, 32'h0);
    chk("t6_b_old", ib1.readdata, 32'hDEAD0000);
    @(negedge clk); idle(); #1;
    chk("t6_new_data", ia1.readdata, 32'hBEEF0001);
    chk("t6_b_oor_vld", {31'b0, ib1.readdatavalid}, 32'h1);
    chk("t6_b_oor_data", ib1.readdata, 32'h0);

    // reset with a read in flight
    @(negedge clk); p1(1, 1, 0, 5'd5, 4'h0, 32'h0);
    @(negedge clk); idle(); reset_n = 1'b0; #1;
    chk("t5_b_vld_pre", {31'b0, ib1.readdatavalid}, 32'h0);
    @(negedge clk); reset_n = 1'b1; #1;
    chk("t5_b_vld", {31'b0, ib1.readdatavalid}, 32'h0);
    chk("t5_b_data", ib1.readdata, 32'h0);
    chk("t5_a_data", ia1.readdata, 32'h0);
    chk("t5_coll_clr", {31'b0, coll_a}, 32'h0);
    @(negedge clk); #1;
    chk("t5_b_vld_late", {31'b0, ib1.readdatavalid}, 32'h0);
    @(negedge clk); p1(1, 1, 0, 5'd5, 4'h0, 32'h0);
    @(negedge clk); idle(); #1;
    chk("t5_a_keep", ia1.readdata, 32'h12BB56DD);
    @(negedge clk); #1;
    chk("t5_b_keep", ib1.readdata, 32'h12BB56DD);
    chk("t5_b_keep_vld", {31'b0, ib1.readdatavalid}, 32'h1);

    // latency 2 stream with a 3-cycle clken stall
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p1(1, 0, 1, 5'(i), 4'hF, 32'hA0 + 32'(i));
    end
    @(negedge clk); idle();
    repeat (2) @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      clken = !(c >= 2 && c <= 4);
      case (c)
        0: p1(1, 1, 0, 5'd0, 4'h0, 32'h0);
        1: p1(1, 1, 0, 5'd1, 4'h0, 32'h0);
        2, 3, 4, 5: p1(1, 1, 0, 5'd2, 4'h0, 32'h0);
        6: p1(1, 1, 0, 5'd3, 4'h0, 32'h0);
        default: idle();
      endcase
      #1;
      chk($sformatf("t4_vld_c%0d", c),
          {31'b0, ib1.readdatavalid},
          (c >= 5 && c <= 8) ? 32'h1 : 32'h0);
      if (c >= 5 && c <= 8)
        chk($sformatf("t4_data_c%0d", c),
            ib1.readdata, 32'hA0 + 32'(c - 5));
    end
    clken = 1'b1;

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
